fifo_word_unpacker: RTL and testbench

Downstream consumer of the 32-bit synchronous FIFO buffer in the CNN datapath.
- Pops one 32-bit word at a time from the FIFO.
- Splits each word into four 8-bit activations, LSB lane first.
- Streams the activations to the PE input over a valid/ready handshake.
- Marks the last activation of each frame of FRAME_WORDS words.

---
 rtl/cnn_stream_pkg.sv | 28 ++
 rtl/word_lane_sel.sv | 29 ++
 rtl/fifo_word_unpacker.sv | 169 ++++++++++++++++
 tb/tb_fifo_word_unpacker.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_stream_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cnn_stream_pkg                                                         |
// | Shared widths, unpacker FSM encoding and width helper for CNN streams. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package cnn_stream_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    EMIT     = 2'd3
  } unpack_state_e;

  // Counter/index width for n values; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_lane_sel.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | word_lane_sel                                                          |
// | Combinational mux picking one LANE_W slice of a DATA_W word.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module word_lane_sel
  import cnn_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [DATA_W-1:0]                   word,
  input  logic [clog2(DATA_W/LANE_W)-1:0]     lane_idx,
  output logic [LANE_W-1:0]                   lane_data
);

  localparam int LANES  = DATA_W / LANE_W;
  localparam int LIDX_W = clog2(LANES);

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_idx == i[LIDX_W-1:0]) lane_data = word[i*LANE_W +: LANE_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_word_unpacker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fifo_word_unpacker                                                     |
// | Pops 32-bit FIFO words and streams them LSB lane first to the PE.      |
// | Optional: FIFO_UNPACK_PREFETCH_EN adds a one-word prefetch buffer.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module fifo_word_unpacker
  import cnn_stream_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LANE_W      = DEF_LANE_W,
  parameter int FRAME_WORDS = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [LANE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int LANES  = DATA_W / LANE_W;
  localparam int LIDX_W = clog2(LANES);
  localparam int CNT_W  = clog2(FRAME_WORDS);

  localparam logic [LIDX_W-1:0] c_last_lane = LIDX_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  c_last_word = CNT_W'(FRAME_WORDS - 1);

  unpack_state_e     r_state, w_state_nxt;
  logic [DATA_W-1:0] r_word, w_word_nxt;
  logic [LIDX_W-1:0] r_lane, w_lane_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [LANE_W-1:0] w_lane_data;
  logic [LANE_W-1:0] r_out_data;
  logic              r_fifo_rd, r_out_valid, r_out_last, r_busy;
  logic              w_rd_nxt, w_hs, w_last_lane, w_word_done;

`ifdef FIFO_UNPACK_PREFETCH_EN
  logic [DATA_W-1:0] r_pf_word;
  logic              r_pf_valid, r_pf_rd, r_pf_wait;
  logic              w_pf_issue, w_pf_cap;
`endif

  assign w_hs        = r_out_valid && out_ready;
  assign w_last_lane = (r_lane == c_last_lane);
  assign w_word_done = (r_state == EMIT) && w_hs && w_last_lane;

`ifdef FIFO_UNPACK_PREFETCH_EN
  // Only one read may be in flight: r_pf_rd is the strobe cycle, r_pf_wait the data cycle.
  assign w_pf_issue = (r_state == EMIT) && !r_pf_valid && en && !fifo_empty &&
                      !r_pf_rd && !r_pf_wait && !w_word_done;
  assign w_pf_cap   = r_pf_wait && (r_state == EMIT) && !w_word_done;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_lane_nxt  = r_lane;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE:     if (en && !fifo_empty) w_state_nxt = RD_ISSUE;
      RD_ISSUE: w_state_nxt = RD_WAIT;
      RD_WAIT: begin
        w_word_nxt  = fifo_data;
        w_lane_nxt  = '0;
        w_state_nxt = EMIT;
      end
      EMIT: begin
        if (w_hs) begin
          if (!w_last_lane) begin
            w_lane_nxt = r_lane + 1'b1;
          end else begin
            w_lane_nxt = '0;
            w_cnt_nxt  = (r_cnt == c_last_word) ? '0 : r_cnt + 1'b1;
`ifdef FIFO_UNPACK_PREFETCH_EN
            // Prefer a buffered word, then one arriving now, then one already strobed.
            if (r_pf_valid)                w_word_nxt  = r_pf_word;
            else if (r_pf_wait)            w_word_nxt  = fifo_data;
            else if (r_pf_rd)              w_state_nxt = RD_WAIT;
            else if (en && !fifo_empty)    w_state_nxt = RD_ISSUE;
            else                           w_state_nxt = IDLE;
`else
            if (en && !fifo_empty) w_state_nxt = RD_ISSUE;
            else                   w_state_nxt = IDLE;
`endif
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef FIFO_UNPACK_PREFETCH_EN
    w_rd_nxt = (w_state_nxt == RD_ISSUE) || w_pf_issue;
`else
    w_rd_nxt = (w_state_nxt == RD_ISSUE);
`endif
  end

  word_lane_sel #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_lane_sel (
    .word      (w_word_nxt),
    .lane_idx  (w_lane_nxt),
    .lane_data (w_lane_data)
  );

  // Outputs are registered from next-state values so they line up with r_state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_word      <= '0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_fifo_rd   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_word      <= w_word_nxt;
      r_lane      <= w_lane_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fifo_rd   <= w_rd_nxt;
      r_out_valid <= (w_state_nxt == EMIT);
      r_out_data  <= w_lane_data;
      r_out_last  <= (w_state_nxt == EMIT) && (w_lane_nxt == c_last_lane) &&
                     (w_cnt_nxt == c_last_word);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

`ifdef FIFO_UNPACK_PREFETCH_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_pf_word  <= '0;
      r_pf_valid <= 1'b0;
      r_pf_rd    <= 1'b0;
      r_pf_wait  <= 1'b0;
    end else begin
      r_pf_rd   <= w_pf_issue;
      r_pf_wait <= r_pf_rd;
      if (w_pf_cap) begin
        r_pf_word  <= fifo_data;
        r_pf_valid <= 1'b1;
      end else if (w_word_done && r_pf_valid) begin
        r_pf_valid <= 1'b0;
      end
    end
  end
`endif

  assign fifo_rd   = r_fifo_rd;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_unpacker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fifo_word_unpacker                                                  |
// | Scoreboard bench: FIFO model feeds the DUT, expected lanes are queued. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_fifo_word_unpacker;

  localparam int DATA_W      = 32;
  localparam int LANE_W      = 8;
  localparam int FRAME_WORDS = 2;
  localparam int LANES       = DATA_W / LANE_W;
`ifdef FIFO_UNPACK_PREFETCH_EN
  localparam int EXP_SPAN4   = 16;
`else
  localparam int EXP_SPAN4   = 22;
`endif

  typedef struct packed {
    logic [LANE_W-1:0] data;
    logic              last;
  } exp_t;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b1;
  logic              en = 1'b0;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd;
  logic [LANE_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic              busy;

  exp_t        exp_q[$];
  logic [31:0] fq[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          tb_wcnt = 0;
  int          rd_cnt = 0;
  int          last_cnt = 0;
  logic        prev_rd = 1'b0;

  always #5 Clk = ~Clk;

  fifo_word_unpacker #(
    .DATA_W      (DATA_W),
    .LANE_W      (LANE_W),
    .FRAME_WORDS (FRAME_WORDS)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .en         (en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fq.push_back(w);
    for (int i = 0; i < LANES; i++) begin
      exp_t e;
      e.data = w[i*LANE_W +: LANE_W];
      e.last = (i == LANES - 1) && (tb_wcnt == FRAME_WORDS - 1);
      exp_q.push_back(e);
    end
    tb_wcnt = (tb_wcnt == FRAME_WORDS - 1) ? 0 : tb_wcnt + 1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    @(negedge Clk);
    while (!out_valid && lat < 30) begin
      @(negedge Clk);
      lat++;
    end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Clk);
    while ((busy || exp_q.size() != 0) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    if (busy || exp_q.size() != 0) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Synchronous FIFO model: data appears the cycle after the read strobe.
  always @(posedge Clk) begin
    if (fifo_rd) begin
      rd_cnt++;
      chk("rd_when_empty", 32'(fq.size() == 0), 32'd0);
      if (fq.size() > 0) fifo_data <= fq.pop_front();
    end
  end

  always @(negedge Clk) fifo_empty = (fq.size() == 0);

  always @(negedge Clk) begin : mon
    exp_t e;
    if (fifo_rd) chk("rd_back_to_back", 32'(prev_rd), 32'd0);
    prev_rd = fifo_rd;
    if (Rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
      if (out_last) last_cnt++;
    end
  end

  initial begin
    int lat, r0, l0, span, hs;
    #1 Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    Rst_n = 1'b1;
    en = 1'b1;

    // Single word, free-flowing output
    @(posedge Clk); #1;
    push_word(32'hDDCCBBAA);
    r0 = rd_cnt;
    wait_valid(lat);
    chk("t1_first_latency", 32'(lat), 32'd3);
    for (int i = 1; i < LANES; i++) begin
      @(negedge Clk);
      chk("t1_lane_consec", 32'(out_valid), 32'd1);
    end
    @(negedge Clk);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_rd_pulses", 32'(rd_cnt - r0), 32'd1);

    // PE stall at lane 1
    @(posedge Clk); #1;
    push_word(32'hDDCCBBAA);
    r0 = rd_cnt;
    wait_valid(lat);
    @(posedge Clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("t2_stall_data", 32'(out_data), 32'h000000BB);
      chk("t2_stall_valid", 32'(out_valid), 32'd1);
    end
    @(posedge Clk); #1;
    out_ready = 1'b1;
    wait_idle();
    chk("t2_rd_pulses", 32'(rd_cnt - r0), 32'd1);

    // Frame boundary and word counter wrap
    l0 = last_cnt;
    @(posedge Clk); #1;
    push_word(32'h03020100);
    push_word(32'h13121110);
    push_word(32'h23222120);
    wait_idle();
    chk("t3_last_count", 32'(last_cnt - l0), 32'd1);

    // en dropped during lane 2
    @(posedge Clk); #1;
    push_word(32'h33323130);
    wait_valid(lat);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    en = 1'b0;
    push_word(32'h43424140);
    r0 = rd_cnt;
    repeat (10) @(negedge Clk);
    chk("t4_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_lanes_left", 32'(exp_q.size()), 32'd4);
    @(posedge Clk); #1;
    en = 1'b1;
    wait_idle();
    chk("t4_resume_rd", 32'(rd_cnt - r0), 32'd1);

    // Asynchronous reset mid-word
    @(posedge Clk); #1;
    push_word(32'h54535251);
    wait_valid(lat);
    @(posedge Clk); #3;
    Rst_n = 1'b0;
    #1;
    chk("t5_rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_last", 32'(out_last), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    tb_wcnt = 0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    push_word(32'h64636261);
    wait_valid(lat);
    chk("t5_restart_lane0", 32'(out_data), 32'h00000061);
    wait_idle();

    // Four queued words streamed back to back
    l0 = last_cnt;
    @(posedge Clk); #1;
    push_word(32'h73727170);
    push_word(32'h83828180);
    push_word(32'h93929190);
    push_word(32'hA3A2A1A0);
    wait_valid(lat);
    span = 1;
    hs = 1;
    while (hs < 16 && span < 60) begin
      @(negedge Clk);
      span++;
      if (out_valid && out_ready) hs++;
    end
    chk("t6_span", 32'(span), 32'(EXP_SPAN4));
    wait_idle();
    chk("t6_last_count", 32'(last_cnt - l0), 32'd2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
